id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have these ports: clk in 1, single clock, all state updates on its rising edge.
REQ-002 The block SHALL have rst in 1, reset that is synchronous and active-high.
REQ-003 The block SHALL have these fetch inputs: pc in 16, address of the presented word; instr in 16, instruction word; instr_valid in 1, the word is meaningful this cycle.
REQ-004 The block SHALL have these control inputs: stall in 1, freeze the stage; flush in 1, discard the stage contents.
REQ-005 The block SHALL have these decoded outputs: id_valid out 1; id_pc out 16; opcode out 4; rd, rs, rt out 4 each; imm out 16.
REQ-006 The block SHALL have these control outputs: reg_write, mem_read, mem_write, illegal out 1 each.
REQ-007 The block SHALL have these redirect outputs to the fetch stage: load_pc out 1; pc_in out 16.

Function
REQ-008 All outputs SHALL be registered; a word accepted at edge N SHALL appear on the outputs after edge N (1-cycle latency).
REQ-009 A word SHALL be accepted only when state=RUN, instr_valid=1, stall=0 and flush=0.
REQ-010 If no word is accepted and stall=0, id_valid SHALL be 0 the next cycle.
REQ-011 Decode fields SHALL be: opcode=instr[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
REQ-012 Opcodes 0x0 to 0x7 (NOP, ADD, SUB, AND, OR, XOR, SHL, SHR) SHALL set reg_write=1, except NOP, which sets it to 0; imm=0.
REQ-013 Opcode 0x8 (ADDI) SHALL set reg_write=1 and imm=sign-extend(instr[3:0]).
REQ-014 Opcode 0x9 (LDI) SHALL set reg_write=1 and imm=sign-extend(instr[7:0]).
REQ-015 Opcode 0xA (LD) SHALL set mem_read=1 and reg_write=1.
REQ-016 Opcode 0xB (ST) SHALL set mem_write=1.
REQ-017 Opcodes 0xC to 0xE SHALL set illegal=1, with all other control bits 0 and id_valid=1.
REQ-018 Opcode 0xF (JMP) SHALL set imm=sign-extend(instr[11:0]), with all write/read controls 0.
REQ-019 On JMP accept, the block SHALL register pc_in=pc+imm (16-bit, wraps modulo 2^16), pulse load_pc=1 for exactly one cycle, and enter REDIRECT.
REQ-020 The state machine SHALL have states RUN, REDIRECT and SQUASH.
REQ-021 In REDIRECT, load_pc SHALL return to 0, the presented word SHALL be discarded (id_valid=0), and the next state SHALL be SQUASH.
REQ-022 In SQUASH, the presented word SHALL be discarded and the next state SHALL be RUN.
REQ-023 REDIRECT and SQUASH SHALL advance only on cycles with stall=0; load_pc SHALL still drop after one cycle regardless of stall.
REQ-024 While stall=1 (and flush=0), all decoded outputs and the state SHALL hold.
REQ-025 flush=1 SHALL force id_valid=0, load_pc=0 and state=RUN at the next edge, with priority over stall and JMP accept.
REQ-026 Priority SHALL be rst, then flush, then stall, then accept.
REQ-027 pc_in SHALL hold its last value when load_pc=0.

Reset
REQ-028 rst=1 at an edge SHALL set state=RUN and force id_valid, load_pc, reg_write, mem_read, mem_write and illegal to 0.
REQ-029 rst=1 at an edge SHALL clear id_pc, pc_in, imm, opcode, rd, rs and rt to 0.
REQ-030 Reset mid-REDIRECT or mid-SQUASH SHALL abandon the squash, with no load_pc pulse after reset.

Structure
REQ-031 Opcode constants (0x0 to 0xF) and state encodings SHALL live in a shared definitions package, ooca_defs, reused by later stages.
REQ-032 Combinational decode (instr to fields, controls, imm) SHALL be one sub-module, id_decoder; id_stage holds the registers and the state machine.

Verification
REQ-033 The bench SHALL check reset: rst=1 for 2 cycles -> all outputs 0, state RUN.
REQ-034 The bench SHALL check ADDI: instr=0x8123, pc=0x0010 -> the next cycle gives id_valid=1, rd=1, rs=2, imm=0x0003, reg_write=1, id_pc=0x0010.
REQ-035 The bench SHALL check JMP with wrap: pc=0xFFFE, instr=0xF005 -> load_pc=1 for one cycle with pc_in=0x0003, the next two presented words discarded, and the third accepted.
REQ-036 The bench SHALL check stall: stall=1 for 3 cycles after an accepted LD -> outputs unchanged; then stall=0 with a new word -> the new word decoded.
REQ-037 The bench SHALL check flush during SQUASH together with stall=1 -> the next cycle gives id_valid=0 and state RUN, and the following valid word is accepted.
REQ-038 The bench SHALL check the illegal opcode: instr=0xD000 -> illegal=1, id_valid=1, reg_write=mem_read=mem_write=0.

Source files
------------

// File: rtl/ooca_defs.sv
// Shared opcode and pipeline-state definitions for the ooca core stages.
package ooca_defs;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDI  = 4'h9,
    OP_LD   = 4'hA,
    OP_ST   = 4'hB,
    OP_RSVC = 4'hC,
    OP_RSVD = 4'hD,
    OP_RSVE = 4'hE,
    OP_JMP  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SQUASH   = 2'd2
  } id_state_e;

endpackage

// File: rtl/id_decoder.sv
// Pure combinational instruction decode: fields, control bits and immediate.
module id_decoder
  import ooca_defs::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal,
  output logic        is_jmp
);

  opcode_e op;

  assign op     = opcode_e'(instr[15:12]);
  assign opcode = instr[15:12];
  assign rd     = instr[11:8];
  assign rs     = instr[7:4];
  assign rt     = instr[3:0];

  always_comb begin
    imm       = 16'h0000;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    is_jmp    = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: reg_write = 1'b1;
      OP_ADDI: begin
        reg_write = 1'b1;
        imm       = {{12{instr[3]}}, instr[3:0]};
      end
      OP_LDI: begin
        reg_write = 1'b1;
        imm       = {{8{instr[7]}}, instr[7:0]};
      end
      OP_LD: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      OP_ST:  mem_write = 1'b1;
      OP_JMP: begin
        is_jmp = 1'b1;
        imm    = {{4{instr[11]}}, instr[11:0]};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: registers decoded fields and squashes the two words behind a taken JMP.
//   state       | meaning
//   ST_RUN      | accepting words from fetch
//   ST_REDIRECT | load_pc just pulsed; drop the word already in flight
//   ST_SQUASH   | drop the second word fetched before the redirect landed
module id_stage
  import ooca_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [15:0] id_pc,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal,
  output logic        load_pc,
  output logic [15:0] pc_in
);

  id_state_e   state, state_next;
  logic        accept;
  logic [3:0]  dec_opcode, dec_rd, dec_rs, dec_rt;
  logic [15:0] dec_imm;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_illegal, dec_jmp;

  id_decoder u_dec (
    .instr     (instr),
    .opcode    (dec_opcode),
    .rd        (dec_rd),
    .rs        (dec_rs),
    .rt        (dec_rt),
    .imm       (dec_imm),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .illegal   (dec_illegal),
    .is_jmp    (dec_jmp)
  );

  assign accept = (state == ST_RUN) && instr_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_RUN;
    end else if (!stall) begin
      case (state)
        ST_RUN:      if (accept && dec_jmp) state_next = ST_REDIRECT;
        ST_REDIRECT: state_next = ST_SQUASH;
        ST_SQUASH:   state_next = ST_RUN;
        default:     state_next = ST_RUN;
      endcase
    end
  end

  // load_pc defaults low every cycle so the redirect pulse never outlives one edge, stall or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid  <= 1'b0;
      id_pc     <= 16'h0000;
      opcode    <= 4'h0;
      rd        <= 4'h0;
      rs        <= 4'h0;
      rt        <= 4'h0;
      imm       <= 16'h0000;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      illegal   <= 1'b0;
      load_pc   <= 1'b0;
      pc_in     <= 16'h0000;
    end else begin
      load_pc <= 1'b0;
      if (flush) begin
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_valid <= accept;
        if (accept) begin
          id_pc     <= pc;
          opcode    <= dec_opcode;
          rd        <= dec_rd;
          rs        <= dec_rs;
          rt        <= dec_rt;
          imm       <= dec_imm;
          reg_write <= dec_reg_write;
          mem_read  <= dec_mem_read;
          mem_write <= dec_mem_write;
          illegal   <= dec_illegal;
          if (dec_jmp) begin
            pc_in   <= pc + dec_imm;
            load_pc <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: behavioural model feeds an expected-output queue, a monitor compares.
module tb_id_stage;

  typedef struct packed {
    logic        id_valid;
    logic [15:0] id_pc;
    logic [3:0]  opcode, rd, rs, rt;
    logic [15:0] imm;
    logic        reg_write, mem_read, mem_write, illegal, load_pc;
    logic [15:0] pc_in;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0, instr = '0;
  logic        instr_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        id_valid, reg_write, mem_read, mem_write, illegal, load_pc;
  logic [15:0] id_pc, imm, pc_in;
  logic [3:0]  opcode, rd, rs, rt;

  id_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .illegal(illegal), .load_pc(load_pc), .pc_in(pc_in)
  );

  always #5 clk = ~clk;

  obs_t  act;
  assign act = '{id_valid, id_pc, opcode, rd, rs, rt, imm,
                 reg_write, mem_read, mem_write, illegal, load_pc, pc_in};

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  // Model: outputs hold unless something changes them; m_skip = words still to drop after a JMP.
  obs_t m = '0;
  int   m_skip = 0;

  function automatic logic [15:0] sext(int v, int bits);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  task automatic model_step(input logic r, f, s, v, input logic [15:0] p, i);
    int op;
    op = int'(i) / 4096;
    if (r) begin
      m = '0; m_skip = 0;
    end else if (f) begin
      m.id_valid = 0; m.load_pc = 0; m_skip = 0;
    end else if (s) begin
      m.load_pc = 0;
    end else if (m_skip > 0) begin
      m_skip--; m.id_valid = 0; m.load_pc = 0;
    end else if (!v) begin
      m.id_valid = 0; m.load_pc = 0;
    end else begin
      m.id_valid = 1; m.id_pc = p; m.load_pc = 0;
      m.opcode = 4'(op);
      m.rd = 4'((int'(i) / 256) % 16);
      m.rs = 4'((int'(i) / 16) % 16);
      m.rt = 4'(int'(i) % 16);
      m.imm = 0; m.reg_write = 0; m.mem_read = 0; m.mem_write = 0; m.illegal = 0;
      if (op >= 1 && op <= 7) m.reg_write = 1;
      else if (op == 8) begin m.reg_write = 1; m.imm = sext(int'(i) % 16, 4); end
      else if (op == 9) begin m.reg_write = 1; m.imm = sext(int'(i) % 256, 8); end
      else if (op == 10) begin m.reg_write = 1; m.mem_read = 1; end
      else if (op == 11) m.mem_write = 1;
      else if (op >= 12 && op <= 14) m.illegal = 1;
      else if (op == 15) begin
        m.imm = sext(int'(i) % 4096, 12);
        m.pc_in = 16'((int'(p) + int'(m.imm)) % 65536);
        m.load_pc = 1;
        m_skip = 2;
      end
    end
  endtask

  task automatic step(input logic r, f, s, v, input logic [15:0] p, i, input string tag);
    @(negedge clk);
    rst = r; flush = f; stall = s; instr_valid = v; pc = p; instr = i;
    model_step(r, f, s, v, p, i);
    exp_q.push_back(m);
    tag_q.push_back(tag);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, a, e);
    end
  endtask

  initial begin : monitor
    obs_t  e;
    string t;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h want %h", t, act, e);
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] ri;
    int budget;
    step(1, 0, 0, 0, 16'h0, 16'h0, "reset0");
    step(1, 0, 0, 1, 16'h1234, 16'h8123, "reset1"); settle();
    chk("reset_all_zero_lo", act[15:0], 16'h0);
    chk("reset_all_zero_hi", 16'(act[69:16] != '0), 16'h0);

    step(0, 0, 0, 1, 16'h0010, 16'h8123, "addi"); settle();
    chk("addi_valid", 16'(id_valid), 16'h1);
    chk("addi_rd", 16'(rd), 16'h1);
    chk("addi_rs", 16'(rs), 16'h2);
    chk("addi_imm", imm, 16'h0003);
    chk("addi_rw", 16'(reg_write), 16'h1);
    chk("addi_pc", id_pc, 16'h0010);

    step(0, 0, 0, 1, 16'hFFFE, 16'hF005, "jmp"); settle();
    chk("jmp_load_pc", 16'(load_pc), 16'h1);
    chk("jmp_pc_in", pc_in, 16'h0003);
    step(0, 0, 0, 1, 16'h0000, 16'h1111, "jmp_drop1"); settle();
    chk("jmp_pulse_end", 16'(load_pc), 16'h0);
    chk("jmp_drop1", 16'(id_valid), 16'h0);
    chk("jmp_pc_in_hold", pc_in, 16'h0003);
    step(0, 0, 0, 1, 16'h0002, 16'h2222, "jmp_drop2"); settle();
    chk("jmp_drop2", 16'(id_valid), 16'h0);
    step(0, 0, 0, 1, 16'h0003, 16'h9234, "jmp_third"); settle();
    chk("jmp_third_valid", 16'(id_valid), 16'h1);
    chk("jmp_third_pc", id_pc, 16'h0003);
    chk("jmp_third_imm", imm, 16'h0034);

    step(0, 0, 0, 1, 16'h0020, 16'hA567, "ld");
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 16'h0030 + 16'(k), 16'h1ABC, "ld_stall"); settle();
      chk("stall_pc_hold", id_pc, 16'h0020);
      chk("stall_mr_hold", 16'(mem_read), 16'h1);
    end
    step(0, 0, 0, 1, 16'h0024, 16'h2345, "after_stall"); settle();
    chk("after_stall_op", 16'(opcode), 16'h2);
    chk("after_stall_pc", id_pc, 16'h0024);

    step(0, 0, 0, 1, 16'h0100, 16'hF7FF, "jmp2"); settle();
    chk("jmp2_pc_in", pc_in, 16'h08FF);
    step(0, 0, 0, 1, 16'h0101, 16'h1111, "jmp2_drop1");
    step(0, 1, 1, 1, 16'h0102, 16'h1111, "flush_squash"); settle();
    chk("flush_valid", 16'(id_valid), 16'h0);
    step(0, 0, 0, 1, 16'h0040, 16'h3456, "post_flush"); settle();
    chk("post_flush_valid", 16'(id_valid), 16'h1);
    chk("post_flush_pc", id_pc, 16'h0040);

    step(0, 0, 0, 1, 16'h0050, 16'hD000, "illegal"); settle();
    chk("ill_flag", 16'(illegal), 16'h1);
    chk("ill_valid", 16'(id_valid), 16'h1);
    chk("ill_ctrl", {13'h0, reg_write, mem_read, mem_write}, 16'h0);

    for (int n = 0; n < 600; n++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 99) < 15) ri[15:12] = 4'hF;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 80,
           16'($urandom), ri, "random");
    end
    step(0, 0, 0, 0, 16'h0, 16'h0, "drain");

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk); budget--;
    end
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
